round_key_sequencer: RTL
========================

Name: round_key_sequencer

Overview:
- Sits directly downstream of the combinational AES-128 key expansion.
- Snapshots the eleven 128-bit round keys into a local register bank, then issues them one per handshake to an iterative round datapath.
- Issue order is round 0..10 for encryption and round 10..0 for decryption.
- A programmable settle delay turns the deep key-expansion cone into a multicycle path, so it does not need to close timing in one cycle.

Parameters:
- SETTLE_CYCLES, 2, cycles to wait after start before sampling the round-key inputs (legal range 1..15).
- NUM_ROUNDS, 10, index of the last round key; fixed at 10 for AES-128.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- i_Key_S0 .. i_Key_S10  input  128 each  round keys 0..10 from key expansion.
- i_Start  input  1  single-cycle request to begin a sequence; honoured only in IDLE.
- i_Decrypt  input  1  direction select, sampled with i_Start (1 = issue 10..0).
- i_Ready  input  1  consumer accepts o_Round_Key this cycle.
- o_Round_Key  output  128  current round key.
- o_Round_Idx  output  4  round number of o_Round_Key.
- o_Valid  output  1  o_Round_Key and o_Round_Idx are valid.
- o_Last  output  1  current key is the final one of the sequence.
- o_Busy  output  1  sequence in progress (SETTLE or ISSUE).
- o_Done  output  1  one-cycle pulse after the final key is accepted.

Behaviour:
- Reset (asynchronous assert, rst_n low): state IDLE; all outputs 0; settle counter 0; direction flag 0; register bank cleared to 0.
- States: IDLE, SETTLE, ISSUE, DONE.
- IDLE:
  - i_Start=1 latches i_Decrypt into the direction flag.
  - Loads the settle counter with SETTLE_CYCLES-1 and goes to SETTLE.
  - o_Busy rises in the next cycle.
- SETTLE:
  - Counter decrements each cycle.
  - At count 0, all eleven i_Key_S* are captured into the bank on that edge.
  - Round index initialises to 0 (encrypt) or 10 (decrypt).
  - State goes to ISSUE.
  - Total latency from i_Start to first o_Valid is SETTLE_CYCLES+1 cycles.
- ISSUE:
  - o_Valid=1; o_Round_Key = bank[idx], driven from a register, not a combinational mux of the inputs.
  - o_Round_Idx = idx.
  - o_Last=1 when idx == 10 (encrypt) or idx == 0 (decrypt).
  - Handshake completes on a cycle with o_Valid=1 and i_Ready=1.
  - Without i_Ready, the key, index and o_Last hold stable. o_Valid never drops before acceptance.
  - On acceptance of a non-last key, idx steps by +1 (encrypt) or -1 (decrypt); the next key is presented in the following cycle.
  - Back-to-back acceptance is allowed: one key per cycle when i_Ready is held high, giving 11 consecutive valid cycles.
  - On acceptance of the last key, the state goes to DONE.
- DONE:
  - o_Done=1 for exactly one cycle; o_Valid=0; o_Busy=0.
  - Next state is IDLE.
- i_Start while in SETTLE, ISSUE or DONE is ignored; there is no queueing.
- i_Key_S* changes after the capture edge have no effect on the running sequence. Changes during SETTLE are harmless as long as they are stable by the capture edge.
- i_Decrypt changes after i_Start are ignored.
- idx never wraps: no step is taken beyond 10 or below 0.
- rst_n asserted mid-sequence: immediate return to the reset state, o_Valid drops asynchronously, and no o_Done pulse is produced.
- Bank contents persist across sequences but are always re-captured before each new sequence.

Test Plan:
- Reset, then an encrypt run with i_Ready=1. Inputs are the FIPS-197 A.1 schedule (S0=2b7e1516_28aed2a6_abf71588_09cf4f3c, S1=a0fafe17_88542cb1_23a33939_2a6c7605, S10=d014f9a8_c9ee2589_e13f0cc8_b6630ca6). Required response:
  - first o_Valid 3 cycles after i_Start (SETTLE_CYCLES=2);
  - 11 consecutive keys with idx 0..10, the first being S0;
  - o_Last only with S10;
  - o_Done one cycle after the last acceptance.
- Decrypt run with the same keys -> first key S10 at idx 10, last key S0 at idx 0 with o_Last=1, then o_Done.
- Random i_Ready stalls (e.g. low for 3 cycles at idx 4) -> o_Round_Key and o_Round_Idx stay frozen at S4/4 for the whole stall; no key skipped or duplicated; 11 acceptances total.
- Change all i_Key_S* to 0 one cycle after the capture edge, plus a second i_Start mid-sequence -> original FIPS keys still issued; second start ignored; exactly one o_Done.
- Deassert rst_n at idx 6 -> o_Valid, o_Busy, o_Round_Key go to 0 immediately; no o_Done; a fresh i_Start afterwards replays from idx 0.
- SETTLE_CYCLES=1 build -> first o_Valid 2 cycles after i_Start; otherwise identical sequence.

Source files
------------

// File: rtl/round_key_sequencer.sv
// AES-128 round-key sequencer. It waits a programmable settle delay after start,
// snapshots the eleven expanded round keys, and then issues them one per ready/valid handshake.
module round_key_sequencer #(
    parameter int SETTLE_CYCLES = 2,
    parameter int NUM_ROUNDS    = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [127:0] i_Key_S0,
    input  logic [127:0] i_Key_S1,
    input  logic [127:0] i_Key_S2,
    input  logic [127:0] i_Key_S3,
    input  logic [127:0] i_Key_S4,
    input  logic [127:0] i_Key_S5,
    input  logic [127:0] i_Key_S6,
    input  logic [127:0] i_Key_S7,
    input  logic [127:0] i_Key_S8,
    input  logic [127:0] i_Key_S9,
    input  logic [127:0] i_Key_S10,
    input  logic         i_Start,
    input  logic         i_Decrypt,
    input  logic         i_Ready,
    output logic [127:0] o_Round_Key,
    output logic [3:0]   o_Round_Idx,
    output logic         o_Valid,
    output logic         o_Last,
    output logic         o_Busy,
    output logic         o_Done
);

    localparam logic [3:0] LP_LAST_IDX    = 4'(NUM_ROUNDS);
    localparam logic [3:0] LP_SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_ISSUE  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t       r_state, w_state_nxt;
    logic [3:0]   r_cnt, w_cnt_nxt;
    logic         r_dec, w_dec_nxt;
    logic [3:0]   r_idx, w_idx_nxt;
    logic [127:0] r_key, w_key_nxt;
    logic         r_valid, w_valid_nxt;
    logic         r_last, w_last_nxt;
    logic         r_busy, w_busy_nxt;
    logic         r_done, w_done_nxt;
    logic         w_capture;
    logic [3:0]   w_idx_step;
    logic         w_last_step;
    logic [127:0] w_key_in [0:NUM_ROUNDS];
    logic [127:0] r_bank   [0:NUM_ROUNDS];

    assign w_key_in[0]  = i_Key_S0;
    assign w_key_in[1]  = i_Key_S1;
    assign w_key_in[2]  = i_Key_S2;
    assign w_key_in[3]  = i_Key_S3;
    assign w_key_in[4]  = i_Key_S4;
    assign w_key_in[5]  = i_Key_S5;
    assign w_key_in[6]  = i_Key_S6;
    assign w_key_in[7]  = i_Key_S7;
    assign w_key_in[8]  = i_Key_S8;
    assign w_key_in[9]  = i_Key_S9;
    assign w_key_in[10] = i_Key_S10;

    // Only evaluated on a non-last key, so the step never runs past 0 or NUM_ROUNDS.
    assign w_idx_step  = r_dec ? (r_idx - 4'd1) : (r_idx + 4'd1);
    assign w_last_step = r_dec ? (w_idx_step == 4'd0) : (w_idx_step == LP_LAST_IDX);

    // Next-state and next-output logic for the sequencer FSM.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_dec_nxt   = r_dec;
        w_idx_nxt   = r_idx;
        w_key_nxt   = r_key;
        w_valid_nxt = r_valid;
        w_last_nxt  = r_last;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_Start) begin
                    w_state_nxt = ST_SETTLE;
                    w_cnt_nxt   = LP_SETTLE_LOAD;
                    w_dec_nxt   = i_Decrypt;
                    w_busy_nxt  = 1'b1;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                if (r_cnt == 4'd0) begin
                    // The first key comes straight from the inputs on the same edge the bank captures them.
                    w_capture   = 1'b1;
                    w_state_nxt = ST_ISSUE;
                    w_idx_nxt   = r_dec ? LP_LAST_IDX : 4'd0;
                    w_key_nxt   = r_dec ? w_key_in[LP_LAST_IDX] : w_key_in[0];
                    w_valid_nxt = 1'b1;
                    w_last_nxt  = 1'b0;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            ST_ISSUE: begin
                if (r_valid && i_Ready) begin
                    if (r_last) begin
                        w_state_nxt = ST_DONE;
                        w_idx_nxt   = 4'd0;
                        w_key_nxt   = 128'd0;
                        w_valid_nxt = 1'b0;
                        w_last_nxt  = 1'b0;
                        w_busy_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_idx_nxt  = w_idx_step;
                        w_key_nxt  = r_bank[w_idx_step];
                        w_last_nxt = w_last_step;
                    end
                end else begin
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = 4'd0;
                w_idx_nxt   = 4'd0;
                w_key_nxt   = 128'd0;
                w_valid_nxt = 1'b0;
                w_last_nxt  = 1'b0;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    // State and registered-output update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
            r_dec   <= 1'b0;
            r_idx   <= 4'd0;
            r_key   <= 128'd0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_dec   <= w_dec_nxt;
            r_idx   <= w_idx_nxt;
            r_key   <= w_key_nxt;
            r_valid <= w_valid_nxt;
            r_last  <= w_last_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // Round-key bank snapshot taken at the end of the settle delay.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i <= NUM_ROUNDS; i++) begin
                r_bank[i] <= 128'd0;
            end
        end else if (w_capture) begin
            for (int i = 0; i <= NUM_ROUNDS; i++) begin
                r_bank[i] <= w_key_in[i];
            end
        end else begin
            for (int i = 0; i <= NUM_ROUNDS; i++) begin
                r_bank[i] <= r_bank[i];
            end
        end
    end

    assign o_Round_Key = r_key;
    assign o_Round_Idx = r_idx;
    assign o_Valid     = r_valid;
    assign o_Last      = r_last;
    assign o_Busy      = r_busy;
    assign o_Done      = r_done;

endmodule
